// File: rtl/execute_feedback_arbiter.sv
// Buffers execute-unit feedback in per-channel FIFOs and forwards up to OUT_NUM
// heads per cycle onto registered wakeup/writeback ports using round-robin arbitration.
module execute_feedback_arbiter #(
    parameter int IN_NUM     = 8,
    parameter int OUT_NUM    = 4,
    parameter int FIFO_DEPTH = 2,
    parameter int PHY_ID_W   = 6,
    parameter int DATA_W     = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [IN_NUM-1:0]            in_valid,
    output logic [IN_NUM-1:0]            in_ready,
    input  logic [IN_NUM*PHY_ID_W-1:0]   in_phy_id,
    input  logic [IN_NUM*DATA_W-1:0]     in_value,
    output logic [OUT_NUM-1:0]           out_valid,
    output logic [OUT_NUM*PHY_ID_W-1:0]  out_phy_id,
    output logic [OUT_NUM*DATA_W-1:0]    out_value,
    output logic                         idle
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int IDX_W = (IN_NUM > 1) ? $clog2(IN_NUM) : 1;
    localparam int ENT_W = PHY_ID_W + DATA_W;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IN_NUM - 1);

    logic [ENT_W-1:0] mem    [IN_NUM][FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr [IN_NUM];
    logic [PTR_W-1:0] rd_ptr [IN_NUM];
    logic [CNT_W-1:0] count  [IN_NUM];
    logic [IDX_W-1:0] rr_ptr;

    logic [IN_NUM-1:0]  push;
    logic [IN_NUM-1:0]  pop;
    logic [IN_NUM-1:0]  not_empty;
    logic [ENT_W-1:0]   head     [IN_NUM];
    logic [OUT_NUM-1:0] port_vld;
    logic [IDX_W-1:0]   port_sel [OUT_NUM];
    logic [IDX_W-1:0]   rr_next;

    // Readiness uses the registered count only, so a full FIFO never accepts while popping.
    always_comb begin
        for (int i = 0; i < IN_NUM; i++) begin
            in_ready[i]  = (count[i] < DEPTH_C) && !flush;
            push[i]      = in_valid[i] && in_ready[i];
            not_empty[i] = (count[i] != '0);
            head[i]      = mem[i][rd_ptr[i]];
        end
    end

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        int idx;
        int n;
        pop     = '0;
        port_vld = '0;
        rr_next = rr_ptr;
        for (int j = 0; j < OUT_NUM; j++) port_sel[j] = '0;
        n = 0;
        for (int k = 0; k < IN_NUM; k++) begin
            idx = (int'(rr_ptr) + k) % IN_NUM;
            if (not_empty[idx] && n < OUT_NUM) begin
                pop[idx]     = 1'b1;
                port_vld[n]  = 1'b1;
                port_sel[n]  = IDX_W'(idx);
                rr_next      = (IDX_W'(idx) == LAST_IDX) ? '0 : IDX_W'(idx + 1);
                n++;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < IN_NUM; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            rr_ptr     <= '0;
            out_valid  <= '0;
            out_phy_id <= '0;
            out_value  <= '0;
        end else if (flush) begin
            for (int i = 0; i < IN_NUM; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            rr_ptr     <= '0;
            out_valid  <= '0;
            out_phy_id <= '0;
            out_value  <= '0;
        end else begin
            for (int i = 0; i < IN_NUM; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
            end
            rr_ptr <= rr_next;
            for (int j = 0; j < OUT_NUM; j++) begin
                out_valid[j] <= port_vld[j];
                out_phy_id[j*PHY_ID_W +: PHY_ID_W] <=
                    port_vld[j] ? head[port_sel[j]][DATA_W +: PHY_ID_W] : '0;
                out_value[j*DATA_W +: DATA_W] <=
                    port_vld[j] ? head[port_sel[j]][DATA_W-1:0] : '0;
            end
        end
    end

    // NOTE: FIFO storage has no reset; count gates every read, so stale entries are never seen.
    always_ff @(posedge clk) begin
        for (int i = 0; i < IN_NUM; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= {in_phy_id[i*PHY_ID_W +: PHY_ID_W],
                                      in_value[i*DATA_W +: DATA_W]};
            end
        end
    end

    assign idle = ~|not_empty && ~|out_valid;

endmodule

// File: tb/tb_execute_feedback_arbiter.sv
// Randomized and directed bench for execute_feedback_arbiter: a queue-based reference
// model predicts every output beat, and a negedge monitor compares against the DUT.
module tb_execute_feedback_arbiter;
    localparam int IN_NUM     = 8;
    localparam int OUT_NUM    = 4;
    localparam int FIFO_DEPTH = 2;
    localparam int PW         = 6;
    localparam int DW         = 32;

    logic                  clk;
    logic                  rst;
    logic                  flush;
    logic [IN_NUM-1:0]     in_valid;
    logic [IN_NUM-1:0]     in_ready;
    logic [IN_NUM*PW-1:0]  in_phy_id;
    logic [IN_NUM*DW-1:0]  in_value;
    logic [OUT_NUM-1:0]    out_valid;
    logic [OUT_NUM*PW-1:0] out_phy_id;
    logic [OUT_NUM*DW-1:0] out_value;
    logic                  idle;

    execute_feedback_arbiter #(
        .IN_NUM(IN_NUM), .OUT_NUM(OUT_NUM), .FIFO_DEPTH(FIFO_DEPTH),
        .PHY_ID_W(PW), .DATA_W(DW)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_phy_id(in_phy_id), .in_value(in_value),
        .out_valid(out_valid), .out_phy_id(out_phy_id), .out_value(out_value),
        .idle(idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int seq   = 1;
    bit mon_en = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one queue per channel, plus the round-robin start index.
    typedef logic [PW+DW-1:0] ent_t;
    typedef struct {
        int            port;
        logic [PW-1:0] phy;
        logic [DW-1:0] val;
    } beat_t;

    ent_t               chq [IN_NUM][$];
    beat_t              exp_q[$];
    int                 rr = 0;
    logic [OUT_NUM-1:0] exp_mask = '0;

    function automatic logic [IN_NUM-1:0] model_ready();
        logic [IN_NUM-1:0] r;
        for (int i = 0; i < IN_NUM; i++) r[i] = (chq[i].size() < FIFO_DEPTH) && !flush;
        return r;
    endfunction

    function automatic logic model_idle();
        logic e;
        e = (exp_mask == '0);
        for (int i = 0; i < IN_NUM; i++) if (chq[i].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < IN_NUM; i++) chq[i].delete();
        exp_q.delete();
        rr = 0;
        exp_mask = '0;
    endtask

    task automatic model_step();
        logic [IN_NUM-1:0] acc;
        int n;
        int last;
        int idx;
        ent_t e;
        beat_t b;
        acc = in_valid & model_ready();
        exp_mask = '0;
        if (flush) begin
            for (int i = 0; i < IN_NUM; i++) chq[i].delete();
            rr = 0;
        end else begin
            n = 0;
            last = -1;
            for (int k = 0; k < IN_NUM; k++) begin
                idx = (rr + k) % IN_NUM;
                if (n < OUT_NUM && chq[idx].size() > 0) begin
                    e = chq[idx].pop_front();
                    b.port = n;
                    b.phy  = e[DW +: PW];
                    b.val  = e[DW-1:0];
                    exp_q.push_back(b);
                    exp_mask[n] = 1'b1;
                    n++;
                    last = idx;
                end
            end
            if (last >= 0) rr = (last + 1) % IN_NUM;
            for (int i = 0; i < IN_NUM; i++)
                if (acc[i]) chq[i].push_back({in_phy_id[i*PW +: PW], in_value[i*DW +: DW]});
        end
    endtask

    always @(posedge clk) if (rst) model_step();

    // Monitor: compares status every cycle and pops one expected beat per valid port.
    always @(negedge clk) begin
        beat_t b;
        if (mon_en) begin
            check("out_valid", 64'(out_valid), 64'(exp_mask));
            check("in_ready", 64'(in_ready), 64'(model_ready()));
            check("idle", 64'(idle), 64'(model_idle()));
            for (int j = 0; j < OUT_NUM; j++) begin
                if (out_valid[j]) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_beat: port %0d phy %0h value %0h, expected none",
                                 j, out_phy_id[j*PW +: PW], out_value[j*DW +: DW]);
                    end else begin
                        b = exp_q.pop_front();
                        check("beat_port", 64'(j), 64'(b.port));
                        check("beat_phy", 64'(out_phy_id[j*PW +: PW]), 64'(b.phy));
                        check("beat_value", 64'(out_value[j*DW +: DW]), 64'(b.val));
                    end
                end
            end
        end
    end

    // Called at posedge+1; leaves at the next posedge+1.
    task automatic drive(input logic [IN_NUM-1:0] v, input logic fl, input bit phy_is_idx);
        in_valid = v;
        flush    = fl;
        for (int i = 0; i < IN_NUM; i++) begin
            in_phy_id[i*PW +: PW] = phy_is_idx ? PW'(i) : PW'($urandom);
            in_value[i*DW +: DW]  = DW'(seq);
            seq++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        mon_en = 0;
        #1;
        rst = 1'b0;
        #1;
        check("async_reset_out_valid", 64'(out_valid), 64'h0);
        check("async_reset_idle", 64'(idle), 64'h1);
        model_clear();
        in_valid = '0;
        flush    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b1;
        mon_en = 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = '0;
        in_phy_id = '0;
        in_value  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 64'(out_valid), 64'h0);
        check("reset_out_value", 64'(out_value), 64'h0);
        rst    = 1'b1;
        mon_en = 1;
        @(posedge clk);
        #1;

        // All channels one cycle with phy=i: two waves of four, rotating.
        drive('1, 1'b0, 1'b1);
        in_valid = '0;
        @(posedge clk);
        @(negedge clk);
        for (int j = 0; j < OUT_NUM; j++)
            check("wave0_phy", 64'(out_phy_id[j*PW +: PW]), 64'(j));
        @(posedge clk);
        @(negedge clk);
        for (int j = 0; j < OUT_NUM; j++)
            check("wave1_phy", 64'(out_phy_id[j*PW +: PW]), 64'(j + 4));
        @(posedge clk);
        #1;
        repeat (2) drive('0, 1'b0, 1'b0);

        // Single uncontended beat: ch3, phy 5, value DEAD, two-cycle latency.
        in_valid = 8'b0000_1000;
        in_phy_id[3*PW +: PW] = 6'd5;
        in_value[3*DW +: DW]  = 32'hDEAD;
        @(posedge clk);
        #1;
        in_valid = '0;
        @(posedge clk);
        @(negedge clk);
        check("single_out_valid", 64'(out_valid), 64'h1);
        check("single_phy", 64'(out_phy_id[PW-1:0]), 64'd5);
        check("single_value", 64'(out_value[DW-1:0]), 64'hDEAD);
        @(posedge clk);
        @(negedge clk);
        check("single_idle_after", 64'(idle), 64'h1);
        @(posedge clk);
        #1;

        // Saturation: every channel valid every cycle, unique values, then drain.
        repeat (40) drive('1, 1'b0, 1'b0);
        repeat (4) drive('0, 1'b0, 1'b0);

        // Flush with FIFOs partly full and ch1 presenting a value that must be dropped.
        drive('1, 1'b0, 1'b0);
        drive(8'b0000_0010, 1'b1, 1'b0);
        repeat (3) drive('0, 1'b0, 1'b0);

        // Random traffic with occasional flushes.
        for (int c = 0; c < 300; c++) begin
            logic [IN_NUM-1:0] v;
            v = ($urandom_range(0, 3) == 0) ? IN_NUM'($urandom) : IN_NUM'($urandom & $urandom);
            drive(v, ($urandom_range(0, 39) == 0), 1'b0);
        end

        // Reset mid-traffic.
        drive('1, 1'b0, 1'b0);
        drive('1, 1'b0, 1'b0);
        do_reset();

        for (int c = 0; c < 100; c++) drive(IN_NUM'($urandom), 1'b0, 1'b0);
        repeat (8) drive('0, 1'b0, 1'b0);

        check("all_beats_delivered", 64'(exp_q.size()), 64'h0);
        check("final_idle", 64'(idle), 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish before 200000");
        $fatal(1);
    end

endmodule
